// File: rtl/serial_compare_ctrl_pkg.sv
// Shared FSM state encoding and one-hot compare result codes for serial_compare_ctrl.
package serial_compare_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] CMP_GT   = 3'b100;
  localparam logic [2:0] CMP_LT   = 3'b010;
  localparam logic [2:0] CMP_EQ   = 3'b001;
  localparam logic [2:0] CMP_NONE = 3'b000;

endpackage

// File: rtl/serial_compare_ctrl_if.sv
// Start/operand request and busy/done/result response bundle of the serial comparator.
interface serial_compare_ctrl_if #(
  parameter int WIDTH = 16
);

  logic             iStart;
  logic [WIDTH-1:0] iData_a;
  logic [WIDTH-1:0] iData_b;
  logic             oBusy;
  logic             oDone;
  logic [2:0]       oData;

  modport master (
    output iStart, iData_a, iData_b,
    input  oBusy, oDone, oData
  );

  modport slave (
    input  iStart, iData_a, iData_b,
    output oBusy, oDone, oData
  );

endinterface

// File: rtl/serial_compare_ctrl_cmp.sv
// One nibble step of the magnitude compare: a differing nibble decides, an equal one
// passes the lower-order cascade through (a malformed cascade counts as equal).
module nibble_cmp
  import serial_compare_ctrl_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] cascade_in,
  output logic [2:0] result
);

  always_comb begin
    result = CMP_EQ;
    if (a > b) begin
      result = CMP_GT;
    end else if (a < b) begin
      result = CMP_LT;
    end else if ($onehot(cascade_in)) begin
      result = cascade_in;
    end
  end

endmodule

// File: rtl/serial_compare_ctrl.sv
// Serial magnitude comparator: one nibble per cycle LSB-first, result valid on a
// one-cycle oDone pulse NIBBLES+1 cycles after the start edge; start ignored while busy.
module serial_compare_ctrl
  import serial_compare_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  serial_compare_ctrl_if.slave bus
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [IDXW-1:0]  idx;
  logic [2:0]       cascade;
  logic [2:0]       cmp_res;
  logic [2:0]       data_q;
  logic             last;

  assign last = (idx == LAST_IDX);

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.iStart) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.oBusy = (state != IDLE);
    bus.oDone = (state == DONE);
  end

  // Operands are don't-care outside a compare, so they carry no reset.
  always_ff @(posedge iClk) begin
    if (state == IDLE && bus.iStart) begin
      a_reg <= bus.iData_a;
      b_reg <= bus.iData_b;
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      idx     <= '0;
      cascade <= CMP_EQ;
      data_q  <= CMP_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.iStart) begin
            idx     <= '0;
            cascade <= CMP_EQ;
          end
        end
        RUN: begin
          cascade <= cmp_res;
          if (last) begin
            data_q <= cmp_res;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  nibble_cmp u_nibble_cmp (
    .a          (a_reg[idx*4 +: 4]),
    .b          (b_reg[idx*4 +: 4]),
    .cascade_in (cascade),
    .result     (cmp_res)
  );

  assign bus.oData = data_q;

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Directed bench for serial_compare_ctrl at WIDTH=16 and WIDTH=8.
module tb_serial_compare_ctrl;
  import serial_compare_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_compare_ctrl_if #(.WIDTH(16)) bus16 ();
  serial_compare_ctrl_if #(.WIDTH(8))  bus8 ();

  serial_compare_ctrl #(.WIDTH(16)) dut16 (.iClk(clk), .iRst_n(rst_n), .bus(bus16));
  serial_compare_ctrl #(.WIDTH(8))  dut8  (.iClk(clk), .iRst_n(rst_n), .bus(bus8));

  int n_cmp = 0;
  int n_bad = 0;
  logic [2:0] prev16 = CMP_NONE;
  logic [2:0] prev8  = CMP_NONE;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  exp;
    string       nm;
  } vec_t;
  vec_t vecs[9];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge after the oDone cycle.
  task automatic cmp16(input logic [15:0] a, input logic [15:0] b, input logic [2:0] exp,
                       input string nm);
    int busy_cyc;
    int guard;
    bus16.iStart = 1'b1; bus16.iData_a = a; bus16.iData_b = b;
    @(posedge clk);
    @(negedge clk);
    bus16.iStart = 1'b0; bus16.iData_a = ~a; bus16.iData_b = ~b;
    check({nm, " hold"}, 32'(bus16.oData), 32'(prev16));
    busy_cyc = 0;
    guard = 0;
    while (!bus16.oDone && guard < 20) begin
      if (bus16.oBusy) busy_cyc++;
      guard++;
      @(negedge clk);
    end
    check({nm, " done_seen"}, 32'(bus16.oDone), 32'd1);
    check({nm, " busy_cycles"}, busy_cyc, 32'd4);
    check({nm, " result"}, 32'(bus16.oData), 32'(exp));
    @(negedge clk);
    check({nm, " pulse_end"}, {30'd0, bus16.oDone, bus16.oBusy}, 32'd0);
    prev16 = exp;
  endtask

  task automatic cmp8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] exp,
                      input string nm);
    int busy_cyc;
    int guard;
    bus8.iStart = 1'b1; bus8.iData_a = a; bus8.iData_b = b;
    @(posedge clk);
    @(negedge clk);
    bus8.iStart = 1'b0; bus8.iData_a = ~a; bus8.iData_b = ~b;
    check({nm, " hold"}, 32'(bus8.oData), 32'(prev8));
    busy_cyc = 0;
    guard = 0;
    while (!bus8.oDone && guard < 20) begin
      if (bus8.oBusy) busy_cyc++;
      guard++;
      @(negedge clk);
    end
    check({nm, " done_seen"}, 32'(bus8.oDone), 32'd1);
    check({nm, " busy_cycles"}, busy_cyc, 32'd2);
    check({nm, " result"}, 32'(bus8.oData), 32'(exp));
    @(negedge clk);
    check({nm, " pulse_end"}, {30'd0, bus8.oDone, bus8.oBusy}, 32'd0);
    prev8 = exp;
  endtask

  initial begin
    int guard;
    int period;
    logic seen;

    vecs[0] = '{16'h1234, 16'h1234, CMP_EQ, "eq_1234"};
    vecs[1] = '{16'h8000, 16'h7FFF, CMP_GT, "msb_dom"};
    vecs[2] = '{16'h1230, 16'h1231, CMP_LT, "lsb_lt"};
    vecs[3] = '{16'hFFFF, 16'hFFFE, CMP_GT, "lsb_gt"};
    vecs[4] = '{16'h0000, 16'h0000, CMP_EQ, "eq_zero"};
    vecs[5] = '{16'hABCD, 16'hABCE, CMP_LT, "abcd_lt"};
    vecs[6] = '{16'hF000, 16'h0FFF, CMP_GT, "f000_gt"};
    vecs[7] = '{16'h00FF, 16'h0100, CMP_LT, "mid_lt"};
    vecs[8] = '{16'h0001, 16'h0000, CMP_GT, "one_gt"};

    rst_n = 1'b0;
    bus16.iStart = 1'b0; bus16.iData_a = '0; bus16.iData_b = '0;
    bus8.iStart  = 1'b0; bus8.iData_a  = '0; bus8.iData_b  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst16 busy_done", {30'd0, bus16.oBusy, bus16.oDone}, 32'd0);
    check("rst16 data", 32'(bus16.oData), 32'(CMP_NONE));
    check("rst8 busy_done", {30'd0, bus8.oBusy, bus8.oDone}, 32'd0);
    check("rst8 data", 32'(bus8.oData), 32'(CMP_NONE));
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      cmp16(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].nm);
    end

    // Held start: operands changed after capture must not affect the first result.
    bus16.iStart = 1'b1; bus16.iData_a = 16'h0005; bus16.iData_b = 16'h0003;
    @(posedge clk);
    @(negedge clk);
    bus16.iData_a = 16'h0003; bus16.iData_b = 16'h0005;
    guard = 0;
    while (!bus16.oDone && guard < 20) begin guard++; @(negedge clk); end
    check("held first_done", 32'(bus16.oDone), 32'd1);
    check("held first_result", 32'(bus16.oData), 32'(CMP_GT));
    @(negedge clk);
    check("held idle_gap", 32'(bus16.oBusy), 32'd0);
    period = 1;
    while (!bus16.oDone && period < 20) begin period++; @(negedge clk); end
    check("held period", period, 32'd6);
    check("held second_result", 32'(bus16.oData), 32'(CMP_LT));
    bus16.iStart = 1'b0;
    @(negedge clk);
    check("held stop_idle", {30'd0, bus16.oBusy, bus16.oDone}, 32'd0);
    @(negedge clk);
    check("held stays_idle", 32'(bus16.oBusy), 32'd0);
    prev16 = CMP_LT;

    // Reset while idx==2 abandons the compare.
    bus16.iStart = 1'b1; bus16.iData_a = 16'h0F00; bus16.iData_b = 16'h0100;
    @(posedge clk);
    @(negedge clk);
    bus16.iStart = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst busy_done", {30'd0, bus16.oBusy, bus16.oDone}, 32'd0);
    check("midrst data", 32'(bus16.oData), 32'(CMP_NONE));
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus16.oDone || bus16.oBusy) seen = 1'b1;
    end
    check("midrst no_pulse", 32'(seen), 32'd0);
    prev16 = CMP_NONE;
    prev8  = CMP_NONE;
    cmp16(16'h0001, 16'h0000, CMP_GT, "post_rst");

    cmp8(8'hF0, 8'h0F, CMP_GT, "w8_f0_gt");
    cmp8(8'h0F, 8'hF0, CMP_LT, "w8_0f_lt");
    cmp8(8'h55, 8'h55, CMP_EQ, "w8_eq");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
